// File: rtl/ili9341_sequencer_pkg.sv
// Shared types and constants for the ILI9341 bring-up / frame sequencer.
package ili9341_sequencer_pkg;

  // Default timing for a 100 MHz system clock and a 240x320 panel
  localparam int DEF_RST_CYC   = 1000;
  localparam int DEF_POR_CYC   = 12_000_000;
  localparam int DEF_SLP_CYC   = 12_000_000;
  localparam int DEF_PIX_TOTAL = 76800;

  // Command-array selector understood by send_command
  localparam logic INI_COMM  = 1'b0;
  localparam logic LOOP_COMM = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HWRST     = 4'd1,
    ST_RST_WAIT  = 4'd2,
    ST_INIT      = 4'd3,
    ST_INIT_WAIT = 4'd4,
    ST_SLP_WAIT  = 4'd5,
    ST_LOOP_CMD  = 4'd6,
    ST_LOOP_WAIT = 4'd7,
    ST_PIXELS    = 4'd8,
    ST_FRAME_END = 4'd9
`ifdef FRAME_SYNC_EN
    ,
    ST_SYNC_WAIT = 4'd10
`endif
  } seq_state_t;

  // Largest of three cycle counts, used to size the shared delay counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ili9341_sequencer_if.sv
// Handshake bundle between the sequencer and the command / pixel senders.
// master = sequencer side, slave = sender side.
interface ili9341_sequencer_if;
  logic o_send_comm_ena;    // 1-cycle start pulse to send_command
  logic o_command;          // INI_COMM / LOOP_COMM array select
  logic o_pix_ena;          // pixel sender enable (level)
  logic o_mux_sel;          // SPI path: 0 = command sender, 1 = pixel sender
  logic i_comm_array_sent;  // send_command finished its array
  logic i_pixel_sent;       // one pixel shifted out

  modport master (
    output o_send_comm_ena, o_command, o_pix_ena, o_mux_sel,
    input  i_comm_array_sent, i_pixel_sent
  );

  modport slave (
    input  o_send_comm_ena, o_command, o_pix_ena, o_mux_sel,
    output i_comm_array_sent, i_pixel_sent
  );
endinterface

// File: rtl/ili9341_sequencer_dly_cnt.sv
// Shared down-counter for the sequencer's timed states. Loading value N-1
// on state entry makes done_o read high on the N-th cycle in that state.
module ili9341_sequencer_dly_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; otherwise count down and rest at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ili9341_sequencer.sv
// ILI9341 top-level sequencer: panel hardware reset, power-on wait, init
// command array, sleep-out wait, then an endless frame loop of loop command
// array followed by PIX_TOTAL pixels. Owns the SPI path mux select.
// Optional feature macro: FRAME_SYNC_EN -- when defined, each frame after
// the first waits in SYNC_WAIT for an i_frame_sync pulse before restarting.
module ili9341_sequencer
  import ili9341_sequencer_pkg::*;
#(
  parameter int RST_CYC   = DEF_RST_CYC,
  parameter int POR_CYC   = DEF_POR_CYC,
  parameter int SLP_CYC   = DEF_SLP_CYC,
  parameter int PIX_TOTAL = DEF_PIX_TOTAL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_frame_sync,
  ili9341_sequencer_if.master        dp,
  output logic                       o_lcd_rst_n,
  output logic                       o_busy,
  output logic [7:0]                 o_frame_cnt
);

  localparam int DLY_W = $clog2(max3(RST_CYC, POR_CYC, SLP_CYC) + 1);
  localparam int PIX_W = cnt_width(PIX_TOTAL);

  localparam logic [DLY_W-1:0] RST_LD   = DLY_W'(RST_CYC - 1);
  localparam logic [DLY_W-1:0] POR_LD   = DLY_W'(POR_CYC - 1);
  localparam logic [DLY_W-1:0] SLP_LD   = DLY_W'(SLP_CYC - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_TOTAL - 1);

  seq_state_t       state_q, state_d;
  logic             stop_q, stop_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             lcd_rst_n_q, lcd_rst_n_d;
  logic             send_q, send_d;
  logic             cmd_q, cmd_d;
  logic             pix_q, pix_d;
  logic             busy_q, busy_d;

  logic             dly_load_s;
  logic [DLY_W-1:0] dly_value_s;
  logic             dly_done_s;

`ifndef FRAME_SYNC_EN
  // Frame sync has no consumer when the feature is compiled out
  logic unused_frame_sync_s;
  assign unused_frame_sync_s = i_frame_sync;
`endif

  ili9341_sequencer_dly_cnt #(
    .W (DLY_W)
  ) u_dly_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (dly_load_s),
    .value_i (dly_value_s),
    .done_o  (dly_done_s)
  );

  // Next-state logic: sequencing, delay loads and pixel/frame counting
  always_comb begin
    state_d     = state_q;
    dly_load_s  = 1'b0;
    dly_value_s = '0;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_HWRST;
          dly_load_s  = 1'b1;
          dly_value_s = RST_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HWRST: begin
        if (dly_done_s) begin
          state_d     = ST_RST_WAIT;
          dly_load_s  = 1'b1;
          dly_value_s = POR_LD;
        end else begin
          state_d = ST_HWRST;
        end
      end
      ST_RST_WAIT: begin
        if (dly_done_s) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_RST_WAIT;
        end
      end
      ST_INIT: begin
        state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (dp.i_comm_array_sent) begin
          state_d     = ST_SLP_WAIT;
          dly_load_s  = 1'b1;
          dly_value_s = SLP_LD;
        end else begin
          state_d = ST_INIT_WAIT;
        end
      end
      ST_SLP_WAIT: begin
        if (dly_done_s) begin
          state_d = ST_LOOP_CMD;
        end else begin
          state_d = ST_SLP_WAIT;
        end
      end
      ST_LOOP_CMD: begin
        state_d = ST_LOOP_WAIT;
      end
      ST_LOOP_WAIT: begin
        if (dp.i_comm_array_sent) begin
          state_d   = ST_PIXELS;
          pix_cnt_d = '0;
        end else begin
          state_d = ST_LOOP_WAIT;
        end
      end
      ST_PIXELS: begin
        if (dp.i_pixel_sent) begin
          if (pix_cnt_q == PIX_LAST) begin
            state_d     = ST_FRAME_END;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end else begin
          state_d = ST_PIXELS;
        end
      end
      ST_FRAME_END: begin
        // A stop arriving in this very cycle is honoured as if latched
        if (stop_q || i_stop) begin
          state_d = ST_IDLE;
        end else begin
`ifdef FRAME_SYNC_EN
          state_d = ST_SYNC_WAIT;
`else
          state_d = ST_LOOP_CMD;
`endif
        end
      end
`ifdef FRAME_SYNC_EN
      ST_SYNC_WAIT: begin
        if (i_frame_sync) begin
          state_d = ST_LOOP_CMD;
        end else begin
          state_d = ST_SYNC_WAIT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stop request latch: armed while busy, cleared whenever idle
  always_comb begin
    stop_d = stop_q;
    if (state_q == ST_IDLE) begin
      stop_d = 1'b0;
    end else begin
      stop_d = stop_q | i_stop;
    end
  end

  // Output next values, decoded from the state being entered so that the
  // registered outputs line up with the registered state
  always_comb begin
    lcd_rst_n_d = (state_d != ST_HWRST);
    send_d      = (state_d == ST_INIT) || (state_d == ST_LOOP_CMD);
    pix_d       = (state_d == ST_PIXELS);
    busy_d      = (state_d != ST_IDLE);
    cmd_d       = cmd_q;
    if (state_d == ST_LOOP_CMD) begin
      cmd_d = LOOP_COMM;
    end else if (state_d == ST_INIT) begin
      cmd_d = INI_COMM;
    end else begin
      cmd_d = cmd_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      stop_q      <= 1'b0;
      pix_cnt_q   <= '0;
      frame_cnt_q <= 8'd0;
      lcd_rst_n_q <= 1'b0;
      send_q      <= 1'b0;
      cmd_q       <= INI_COMM;
      pix_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_q      <= stop_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      send_q      <= send_d;
      cmd_q       <= cmd_d;
      pix_q       <= pix_d;
      busy_q      <= busy_d;
    end
  end

  assign dp.o_send_comm_ena = send_q;
  assign dp.o_command       = cmd_q;
  assign dp.o_pix_ena       = pix_q;
  assign dp.o_mux_sel       = pix_q;
  assign o_lcd_rst_n        = lcd_rst_n_q;
  assign o_busy             = busy_q;
  assign o_frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_ili9341_sequencer.sv
// Scoreboard bench for ili9341_sequencer with shortened timing
// (RST_CYC=4, POR_CYC=10, SLP_CYC=6, PIX_TOTAL=8). Stimulus pushes the
// output events it predicts (cycle + value); a negedge monitor pops and
// compares them whenever an output changes or a command pulse appears.
module tb_ili9341_sequencer;
  import ili9341_sequencer_pkg::*;

  localparam int RST = 4;
  localparam int POR = 10;
  localparam int SLP = 6;
  localparam int PIX = 8;

  localparam int EV_LCD = 0;
  localparam int EV_CMD = 1;
  localparam int EV_PIX = 2;
  localparam int EV_FRM = 3;
  localparam int EV_BSY = 4;

  typedef struct {
    int cyc;
    int val;
  } evt_t;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_stop;
  logic       i_frame_sync;
  logic       o_lcd_rst_n;
  logic       o_busy;
  logic [7:0] o_frame_cnt;

  ili9341_sequencer_if dp_if ();

  ili9341_sequencer #(
    .RST_CYC   (RST),
    .POR_CYC   (POR),
    .SLP_CYC   (SLP),
    .PIX_TOTAL (PIX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_frame_sync (i_frame_sync),
    .dp           (dp_if),
    .o_lcd_rst_n  (o_lcd_rst_n),
    .o_busy       (o_busy),
    .o_frame_cnt  (o_frame_cnt)
  );

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_frame = 0;
  evt_t q_lcd[$];
  evt_t q_cmd[$];
  evt_t q_pix[$];
  evt_t q_frm[$];
  evt_t q_bsy[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int kind, input int c, input int v);
    evt_t e;
    e.cyc = c;
    e.val = v;
    case (kind)
      EV_LCD:  q_lcd.push_back(e);
      EV_CMD:  q_cmd.push_back(e);
      EV_PIX:  q_pix.push_back(e);
      EV_FRM:  q_frm.push_back(e);
      default: q_bsy.push_back(e);
    endcase
  endtask

  task automatic match_evt(input int kind, input string tag, input int v);
    evt_t e;
    bit   have;
    have = 1'b0;
    case (kind)
      EV_LCD:  if (q_lcd.size() > 0) begin e = q_lcd.pop_front(); have = 1'b1; end
      EV_CMD:  if (q_cmd.size() > 0) begin e = q_cmd.pop_front(); have = 1'b1; end
      EV_PIX:  if (q_pix.size() > 0) begin e = q_pix.pop_front(); have = 1'b1; end
      EV_FRM:  if (q_frm.size() > 0) begin e = q_frm.pop_front(); have = 1'b1; end
      default: if (q_bsy.size() > 0) begin e = q_bsy.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      chk({tag, "_unexpected_at"}, cyc, -1);
    end else begin
      chk({tag, "_cycle"}, cyc, e.cyc);
      chk({tag, "_value"}, v, e.val);
    end
  endtask

  // Output monitor: every change (or command pulse) must match a prediction
  initial begin : monitor
    int p_lcd, p_pix, p_frm, p_bsy, v;
    p_lcd = 0; p_pix = 0; p_frm = 0; p_bsy = 0;
    forever begin
      @(negedge clk);
      v = int'(o_lcd_rst_n);
      if (v != p_lcd) begin match_evt(EV_LCD, "lcd_rst_n", v); p_lcd = v; end
      if (dp_if.o_send_comm_ena) match_evt(EV_CMD, "send_comm", int'(dp_if.o_command));
      v = int'({dp_if.o_pix_ena, dp_if.o_mux_sel});
      if (v != p_pix) begin match_evt(EV_PIX, "pix_mux", v); p_pix = v; end
      v = int'(o_frame_cnt);
      if (v != p_frm) begin match_evt(EV_FRM, "frame_cnt", v); p_frm = v; end
      v = int'(o_busy);
      if (v != p_bsy) begin match_evt(EV_BSY, "busy", v); p_bsy = v; end
    end
  end

  // Waits (bounded) for the next command pulse; also drops a pending frame sync
  task automatic wait_cmd(output int at);
    int n;
    at = -1;
    n  = 0;
    while (n < 60) begin
      @(negedge clk);
      i_frame_sync = 1'b0;
      if (dp_if.o_send_comm_ena) begin
        at = cyc;
        n  = 60;
      end else begin
        n++;
      end
    end
    if (at < 0) chk("send_comm_timeout", at, 0);
  endtask

  task automatic sync_go();
`ifdef FRAME_SYNC_EN
    repeat (2) @(negedge clk);
    i_frame_sync = 1'b1;
    expect_evt(EV_CMD, cyc + 1, int'(LOOP_COMM));
`endif
  endtask

  // Start from IDLE through to the first loop command pulse
  task automatic bring_up(input bit stop_early);
    int c, w;
    @(negedge clk);
    i_start = 1'b1;
    c = cyc;
    expect_evt(EV_LCD, c + 1, 0);
    expect_evt(EV_BSY, c + 1, 1);
    expect_evt(EV_LCD, c + 1 + RST, 1);
    expect_evt(EV_CMD, c + 1 + RST + POR, int'(INI_COMM));
    @(negedge clk); i_start = 1'b0;
    // Strays during HWRST and RST_WAIT must not disturb the timing
    @(negedge clk);
    i_start = 1'b1; dp_if.i_comm_array_sent = 1'b1; dp_if.i_pixel_sent = 1'b1;
    @(negedge clk);
    i_start = 1'b0; dp_if.i_comm_array_sent = 1'b0; dp_if.i_pixel_sent = 1'b0;
    repeat (4) @(negedge clk);
    dp_if.i_comm_array_sent = 1'b1; dp_if.i_pixel_sent = 1'b1;
    @(negedge clk);
    dp_if.i_comm_array_sent = 1'b0; dp_if.i_pixel_sent = 1'b0;
    wait_cmd(w);
    @(negedge clk);
    dp_if.i_comm_array_sent = 1'b1;
    i_stop = stop_early;
    expect_evt(EV_CMD, cyc + 1 + SLP, int'(LOOP_COMM));
    @(negedge clk);
    dp_if.i_comm_array_sent = 1'b0;
    i_stop = 1'b0;
    wait_cmd(w);
  endtask

  // One frame, entered at the negedge showing the loop command pulse
  task automatic run_frame(input int gap, input int stop_k, input bit ends);
    int d, p;
    @(negedge clk); dp_if.i_pixel_sent = 1'b1;
    @(negedge clk);
    dp_if.i_pixel_sent = 1'b0;
    dp_if.i_comm_array_sent = 1'b1;
    d = cyc;
    expect_evt(EV_PIX, d + 1, 3);
    @(negedge clk); dp_if.i_comm_array_sent = 1'b0;
    for (int k = 0; k < PIX; k++) begin
      dp_if.i_pixel_sent = 1'b1;
      i_stop       = (k == stop_k);
      i_frame_sync = (k == 0);
      if (k == PIX - 1) begin
        p = cyc;
        exp_frame = (exp_frame + 1) % 256;
        expect_evt(EV_PIX, p + 1, 0);
        expect_evt(EV_FRM, p + 1, exp_frame);
        if (ends) begin
          expect_evt(EV_BSY, p + 2, 0);
        end else begin
`ifndef FRAME_SYNC_EN
          expect_evt(EV_CMD, p + 2, int'(LOOP_COMM));
`endif
        end
      end
      @(negedge clk);
      dp_if.i_pixel_sent = 1'b0;
      i_stop       = 1'b0;
      i_frame_sync = 1'b0;
      if (k != PIX - 1) repeat (gap) @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int w, q, r;
    rst = 1'b0;
    i_start = 1'b0; i_stop = 1'b0; i_frame_sync = 1'b0;
    dp_if.i_comm_array_sent = 1'b0;
    dp_if.i_pixel_sent = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lcd_rst_n", int'(o_lcd_rst_n), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_frame_cnt", int'(o_frame_cnt), 0);
    chk("rst_command", int'(dp_if.o_command), int'(INI_COMM));
    chk("rst_send_comm", int'(dp_if.o_send_comm_ena), 0);
    chk("rst_pix_ena", int'(dp_if.o_pix_ena), 0);
    chk("rst_mux_sel", int'(dp_if.o_mux_sel), 0);
    @(negedge clk);
    rst = 1'b1;
    expect_evt(EV_LCD, cyc + 1, 1);
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(o_busy), 0);

    // Run 1: a plain frame, then a stop requested mid-pixels
    bring_up(1'b0);
    run_frame(1, -1, 1'b0);
    sync_go();
    wait_cmd(w);
    run_frame(0, 3, 1'b1);
    repeat (3) @(negedge clk);
    // Stop while idle is ignored and must not leak into the next run
    i_stop = 1'b1;
    @(negedge clk); i_stop = 1'b0;

    // Run 2: frame continues, then stop coincident with the last pixel
    bring_up(1'b0);
    run_frame(2, -1, 1'b0);
    sync_go();
    wait_cmd(w);
    run_frame(0, PIX - 1, 1'b1);
    repeat (3) @(negedge clk);

    // Run 3: stop before the first frame still yields one full frame
    bring_up(1'b1);
    run_frame(0, -1, 1'b1);
    repeat (3) @(negedge clk);

    // Run 4: enough frames to wrap the 8-bit frame counter
    bring_up(1'b0);
    for (int i = 0; i < 252; i++) begin
      run_frame(0, -1, 1'b0);
      sync_go();
      wait_cmd(w);
    end
    chk("frame_cnt_after_wrap", int'(o_frame_cnt), exp_frame);

    // Asynchronous reset in the middle of the pixel stream
    @(negedge clk);
    dp_if.i_comm_array_sent = 1'b1;
    expect_evt(EV_PIX, cyc + 1, 3);
    @(negedge clk); dp_if.i_comm_array_sent = 1'b0; dp_if.i_pixel_sent = 1'b1;
    @(negedge clk); dp_if.i_pixel_sent = 1'b0;
    @(negedge clk);
    q = cyc;
    expect_evt(EV_LCD, q + 1, 0);
    expect_evt(EV_PIX, q + 1, 0);
    expect_evt(EV_FRM, q + 1, 0);
    expect_evt(EV_BSY, q + 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_lcd_rst_n", int'(o_lcd_rst_n), 0);
    chk("async_pix_ena", int'(dp_if.o_pix_ena), 0);
    chk("async_mux_sel", int'(dp_if.o_mux_sel), 0);
    chk("async_busy", int'(o_busy), 0);
    chk("async_frame_cnt", int'(o_frame_cnt), 0);
    chk("async_command", int'(dp_if.o_command), int'(INI_COMM));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    r = cyc;
    expect_evt(EV_LCD, r + 1, 1);
    repeat (4) @(negedge clk);

    chk("left_lcd_events", q_lcd.size(), 0);
    chk("left_cmd_events", q_cmd.size(), 0);
    chk("left_pix_events", q_pix.size(), 0);
    chk("left_frame_events", q_frm.size(), 0);
    chk("left_busy_events", q_bsy.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
